// File: rtl/adxl_spi_responder.sv
// SPI-slave stand-in for the ADXL362: decodes 0x0A/0x0B commands, serves the register
// map with auto-increment bursts, and returns samples from a snapshot taken at CS fall.
module adxl_spi_responder #(
    parameter logic [7:0] DEVID_AD  = 8'hAD,
    parameter logic [7:0] DEVID_MST = 8'h1D,
    parameter logic [7:0] PARTID    = 8'hF2
) (
    input  logic        clk,
    input  logic        reset_db,
    input  logic        CS,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [11:0] sample_X,
    input  logic [11:0] sample_Y,
    input  logic [11:0] sample_Z,
    input  logic [11:0] sample_T,
    input  logic        sample_valid,
    output logic [7:0]  power_ctl,
    output logic [7:0]  filter_ctl,
    output logic        measure_en
);
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WR, S_RD, S_IGNORE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cs_sync_q, cs_sync_d, sclk_sync_q, sclk_sync_d;
    logic [1:0]  mosi_sync_q, mosi_sync_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d, addr_q, addr_d, tx_q, tx_d;
    logic        miso_q, miso_d, is_read_q, is_read_d, rd_flag_q, rd_flag_d, dr_q, dr_d;
    logic [7:0]  power_q, power_d, filter_q, filter_d;
    logic [11:0] live_x_q, live_x_d, live_y_q, live_y_d, live_z_q, live_z_d, live_t_q, live_t_d;
    logic [11:0] shd_x_q, shd_x_d, shd_y_q, shd_y_d, shd_z_q, shd_z_d, shd_t_q, shd_t_d;

    logic        cs_fall, cs_rise, sclk_rise, sclk_fall, byte_done;
    logic [7:0]  byte_in, fetch_addr, rd_byte;

    // Index [1] is the synchronized level; [2] is its previous value for edge detection.
    assign cs_fall   =  cs_sync_q[2] & ~cs_sync_q[1];
    assign cs_rise   = ~cs_sync_q[2] &  cs_sync_q[1];
    assign sclk_rise = ~sclk_sync_q[2] &  sclk_sync_q[1];
    assign sclk_fall =  sclk_sync_q[2] & ~sclk_sync_q[1];
    assign byte_in   = {shift_q[6:0], mosi_sync_q[1]};
    assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);
    assign fetch_addr = (state_q == S_ADDR) ? byte_in : addr_q + 8'd1;

    always_comb begin
        rd_byte = 8'h00;
        case (fetch_addr)
            8'h00: rd_byte = DEVID_AD;
            8'h01: rd_byte = DEVID_MST;
            8'h02: rd_byte = PARTID;
            8'h08: rd_byte = shd_x_q[11:4];
            8'h09: rd_byte = shd_y_q[11:4];
            8'h0A: rd_byte = shd_z_q[11:4];
            8'h0B: rd_byte = {7'b0, dr_q};
            8'h0E: rd_byte = shd_x_q[7:0];
            8'h0F: rd_byte = {{4{shd_x_q[11]}}, shd_x_q[11:8]};
            8'h10: rd_byte = shd_y_q[7:0];
            8'h11: rd_byte = {{4{shd_y_q[11]}}, shd_y_q[11:8]};
            8'h12: rd_byte = shd_z_q[7:0];
            8'h13: rd_byte = {{4{shd_z_q[11]}}, shd_z_q[11:8]};
            8'h14: rd_byte = shd_t_q[7:0];
            8'h15: rd_byte = {{4{shd_t_q[11]}}, shd_t_q[11:8]};
            8'h2C: rd_byte = filter_q;
            8'h2D: rd_byte = power_q;
            default: rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        cs_sync_d   = {cs_sync_q[1:0], CS};
        sclk_sync_d = {sclk_sync_q[1:0], SCLK};
        mosi_sync_d = {mosi_sync_q[0], MOSI};
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        tx_d      = tx_q;
        miso_d    = miso_q;
        is_read_d = is_read_q;
        rd_flag_d = rd_flag_q;
        dr_d      = dr_q;
        power_d   = power_q;
        filter_d  = filter_q;
        live_x_d = live_x_q; live_y_d = live_y_q; live_z_d = live_z_q; live_t_d = live_t_q;
        shd_x_d  = shd_x_q;  shd_y_d  = shd_y_q;  shd_z_d  = shd_z_q;  shd_t_d  = shd_t_q;

        if (cs_fall) begin
            shd_x_d = live_x_q; shd_y_d = live_y_q; shd_z_d = live_z_q; shd_t_d = live_t_q;
        end

        if (state_q != S_RD) begin
            miso_d = 1'b0;
        end else if (sclk_fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
        end

        if (cs_rise) begin
            state_d = S_IDLE;
            if (rd_flag_q) dr_d = 1'b0;
        end else begin
            if ((state_q == S_CMD || state_q == S_ADDR || state_q == S_WR || state_q == S_RD)
                && sclk_rise) begin
                shift_d   = byte_in;
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            case (state_q)
                S_IDLE: if (cs_fall) begin
                    state_d   = S_CMD;
                    bit_cnt_d = 3'd0;
                    rd_flag_d = 1'b0;
                end
                S_CMD: if (byte_done) begin
                    is_read_d = (byte_in == 8'h0B);
                    state_d   = (byte_in == 8'h0A || byte_in == 8'h0B) ? S_ADDR : S_IGNORE;
                end
                S_ADDR: if (byte_done) begin
                    addr_d  = byte_in;
                    tx_d    = rd_byte;
                    state_d = is_read_q ? S_RD : S_WR;
                end
                S_WR: if (byte_done) begin
                    addr_d = addr_q + 8'd1;
                    case (addr_q)
                        8'h2C: filter_d = byte_in;
                        8'h2D: power_d  = byte_in;
                        8'h1F: if (byte_in == 8'h52) begin
                            filter_d = 8'h13;
                            power_d  = 8'h00;
                            dr_d     = 1'b0;
                        end
                        default: ;
                    endcase
                end
                S_RD: if (byte_done) begin
                    addr_d = addr_q + 8'd1;
                    tx_d   = rd_byte;
                    if (addr_q >= 8'h0E && addr_q <= 8'h15) rd_flag_d = 1'b1;
                end
                default: ;
            endcase
        end

        // A new sample outranks any clear arriving in the same cycle.
        if (sample_valid) begin
            live_x_d = sample_X; live_y_d = sample_Y; live_z_d = sample_Z; live_t_d = sample_T;
            dr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset_db) begin
        if (reset_db) begin
            cs_sync_q <= 3'b111; sclk_sync_q <= 3'b000; mosi_sync_q <= 2'b00;
            state_q <= S_IDLE; bit_cnt_q <= 3'd0; shift_q <= 8'h00; addr_q <= 8'h00;
            tx_q <= 8'h00; miso_q <= 1'b0; is_read_q <= 1'b0; rd_flag_q <= 1'b0; dr_q <= 1'b0;
            power_q <= 8'h00; filter_q <= 8'h13;
            live_x_q <= '0; live_y_q <= '0; live_z_q <= '0; live_t_q <= '0;
            shd_x_q  <= '0; shd_y_q  <= '0; shd_z_q  <= '0; shd_t_q  <= '0;
        end else begin
            cs_sync_q <= cs_sync_d; sclk_sync_q <= sclk_sync_d; mosi_sync_q <= mosi_sync_d;
            state_q <= state_d; bit_cnt_q <= bit_cnt_d; shift_q <= shift_d; addr_q <= addr_d;
            tx_q <= tx_d; miso_q <= miso_d; is_read_q <= is_read_d; rd_flag_q <= rd_flag_d;
            dr_q <= dr_d; power_q <= power_d; filter_q <= filter_d;
            live_x_q <= live_x_d; live_y_q <= live_y_d; live_z_q <= live_z_d; live_t_q <= live_t_d;
            shd_x_q  <= shd_x_d;  shd_y_q  <= shd_y_d;  shd_z_q  <= shd_z_d;  shd_t_q  <= shd_t_d;
        end
    end

    assign MISO       = miso_q;
    assign power_ctl  = power_q;
    assign filter_ctl = filter_q;
    assign measure_en = (power_q[1:0] == 2'b10);
endmodule
